// File: rtl/sa_fm_feeder.sv
// sa_fm_feeder: front-end issuer for the systolic-array tile controller.
// It accepts one tile command, latches its configuration, and then streams
// nif*k*k feature-map read requests on back-to-back cycles. The loop order is
// cin (outer), then ky, then kx (inner). When the last word has been issued,
// it waits for the downstream controller to retire the tile. It then pulses
// tile_done.
//
// Handshake: tile_start is a command valid. It is taken only when the FSM is
// in IDLE and en=1. There is no ready signal: a command that arrives outside
// IDLE, or while en=0, is dropped and not queued. quantify_add_end is a
// one-cycle pulse, and it is consumed only in DRAIN.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   en                    global enable (gates command accept only)
//   tile_start            command valid
//   nif, k                input channels and kernel size of the tile
//   fm_base_addr          address of (cin=0, ky=0, kx=0)
//   row_stride            address step per ky
//   chan_stride           address step per cin
//   quantify_add_end      tile retired by downstream controller
//   re_fm_en              pulse on the first streamed word
//   nif_mult_k_mult_k     nif*k*k-1, held from the first word until the next accept
//   fm_rd_en, fm_rd_addr  fm buffer read strobe and address
//   tile_busy             high from accept until tile_done inclusive
//   tile_done             one-cycle completion pulse
//   cfg_err               qualifies tile_done when nif==0 or k==0
module sa_fm_feeder #(
  parameter int ADDR_W = 16,
  parameter int NIF_W  = 16,
  parameter int K_W    = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              tile_start,
  input  logic [NIF_W-1:0]  nif,
  input  logic [K_W-1:0]    k,
  input  logic [ADDR_W-1:0] fm_base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] chan_stride,
  input  logic              quantify_add_end,
  output logic              re_fm_en,
  output logic [CNT_W-1:0]  nif_mult_k_mult_k,
  output logic              fm_rd_en,
  output logic [ADDR_W-1:0] fm_rd_addr,
  output logic              tile_busy,
  output logic              tile_done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // The state is visible hierarchically so that checkers can bind to it.
  state_t state, state_nxt;

  logic [NIF_W-1:0]  nif_q;
  logic [K_W-1:0]    k_q;
  logic [ADDR_W-1:0] row_stride_q;
  logic [ADDR_W-1:0] chan_stride_q;
  logic [NIF_W-1:0]  cin;
  logic [K_W-1:0]    ky;
  logic [K_W-1:0]    kx;
  logic [ADDR_W-1:0] chan_ptr;   // base + cin*chan_stride
  logic [ADDR_W-1:0] row_ptr;    // chan_ptr + ky*row_stride
  logic [ADDR_W-1:0] addr;       // row_ptr + kx
  logic              first_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept, bad_cfg, kx_last, ky_last, cin_last, last_word;

  assign accept    = (state == IDLE) && tile_start && en;
  assign bad_cfg   = (nif == '0) || (k == '0);
  assign kx_last   = (kx == k_q - K_W'(1));
  assign ky_last   = (ky == k_q - K_W'(1));
  assign cin_last  = (cin == nif_q - NIF_W'(1));
  assign last_word = kx_last && ky_last && cin_last;

  assign nif_mult_k_mult_k = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    re_fm_en   = 1'b0;
    fm_rd_en   = 1'b0;
    fm_rd_addr = '0;
    tile_busy  = 1'b0;
    tile_done  = 1'b0;
    cfg_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = bad_cfg ? DONE : ISSUE;
      end
      ISSUE: begin
        tile_busy  = 1'b1;
        fm_rd_en   = 1'b1;
        fm_rd_addr = addr;
        re_fm_en   = first_q;
        if (last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        tile_busy = 1'b1;
        if (quantify_add_end) state_nxt = DONE;
      end
      DONE: begin
        tile_busy = 1'b1;
        tile_done = 1'b1;
        cfg_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk. The adders only ever step by +1, by row_stride, or by
  // chan_stride. When ky wraps, both row_ptr and addr restart from the next
  // channel pointer. When kx wraps, addr restarts from the next row pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nif_q         <= '0;
      k_q           <= '0;
      row_stride_q  <= '0;
      chan_stride_q <= '0;
      cin           <= '0;
      ky            <= '0;
      kx            <= '0;
      chan_ptr      <= '0;
      row_ptr       <= '0;
      addr          <= '0;
      first_q       <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else if (accept) begin
      nif_q         <= nif;
      k_q           <= k;
      row_stride_q  <= row_stride;
      chan_stride_q <= chan_stride;
      cin           <= '0;
      ky            <= '0;
      kx            <= '0;
      chan_ptr      <= fm_base_addr;
      row_ptr       <= fm_base_addr;
      addr          <= fm_base_addr;
      first_q       <= 1'b1;
      err_q         <= bad_cfg;
      cnt_q         <= CNT_W'(nif) * CNT_W'(k) * CNT_W'(k) - CNT_W'(1);
    end else if (state == ISSUE) begin
      first_q <= 1'b0;
      if (!kx_last) begin
        kx   <= kx + K_W'(1);
        addr <= addr + ADDR_W'(1);
      end else begin
        kx <= '0;
        if (!ky_last) begin
          ky      <= ky + K_W'(1);
          row_ptr <= row_ptr + row_stride_q;
          addr    <= row_ptr + row_stride_q;
        end else begin
          ky       <= '0;
          cin      <= cin + NIF_W'(1);
          chan_ptr <= chan_ptr + chan_stride_q;
          row_ptr  <= chan_ptr + chan_stride_q;
          addr     <= chan_ptr + chan_stride_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_fm_feeder.sv
// Testbench for sa_fm_feeder. Each tile's read addresses are predicted from
// nested loops of plain arithmetic: (base + cin*chan + ky*row + kx) mod 2^16.
// The predictions go into an expected queue, and each cycle of the stream is
// compared against the head of that queue.
module tb_sa_fm_feeder;

  logic        clk;
  logic        reset;
  logic        en;
  logic        tile_start;
  logic [15:0] nif;
  logic [2:0]  k;
  logic [15:0] fm_base_addr;
  logic [15:0] row_stride;
  logic [15:0] chan_stride;
  logic        quantify_add_end;
  logic        re_fm_en;
  logic [31:0] nif_mult_k_mult_k;
  logic        fm_rd_en;
  logic [15:0] fm_rd_addr;
  logic        tile_busy;
  logic        tile_done;
  logic        cfg_err;

  int n_asserts = 0;
  int n_fail    = 0;

  sa_fm_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .en                (en),
    .tile_start        (tile_start),
    .nif               (nif),
    .k                 (k),
    .fm_base_addr      (fm_base_addr),
    .row_stride        (row_stride),
    .chan_stride       (chan_stride),
    .quantify_add_end  (quantify_add_end),
    .re_fm_en          (re_fm_en),
    .nif_mult_k_mult_k (nif_mult_k_mult_k),
    .fm_rd_en          (fm_rd_en),
    .fm_rd_addr        (fm_rd_addr),
    .tile_busy         (tile_busy),
    .tile_done         (tile_done),
    .cfg_err           (cfg_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re"},   32'(re_fm_en), 0);
    check({tag, "_cnt"},  nif_mult_k_mult_k, 0);
    check({tag, "_rd"},   32'(fm_rd_en), 0);
    check({tag, "_addr"}, 32'(fm_rd_addr), 0);
    check({tag, "_busy"}, 32'(tile_busy), 0);
    check({tag, "_done"}, 32'(tile_done), 0);
    check({tag, "_err"},  32'(cfg_err), 0);
  endtask

  // Runs one tile from accept to return to IDLE. If noise is set, the bench
  // scrambles the configuration inputs and toggles en, tile_start and
  // quantify_add_end while the stream is running.
  task automatic run_tile(input int nif_i, input int k_i, input logic [15:0] base_i,
                          input logic [15:0] rs_i, input logic [15:0] cs_i,
                          input bit noise, input int drain_wait);
    logic [15:0] exp_q[$];
    logic [15:0] exp_a;
    int n;
    n = nif_i * k_i * k_i;
    for (int c = 0; c < nif_i; c++)
      for (int y = 0; y < k_i; y++)
        for (int x = 0; x < k_i; x++)
          exp_q.push_back(16'(int'(base_i) + c * int'(cs_i) + y * int'(rs_i) + x));

    @(negedge clk);
    check("pre_idle_busy", 32'(tile_busy), 0);
    nif = 16'(nif_i); k = 3'(k_i);
    fm_base_addr = base_i; row_stride = rs_i; chan_stride = cs_i;
    tile_start = 1'b1; en = 1'b1; quantify_add_end = 1'b0;
    @(negedge clk);  // cycle T+1
    tile_start = 1'b0;
    if (noise) begin
      nif = 16'($urandom); k = 3'($urandom);
      fm_base_addr = 16'($urandom); row_stride = 16'($urandom); chan_stride = 16'($urandom);
    end

    if (n == 0) begin
      check("err_done", 32'(tile_done), 1);
      check("err_flag", 32'(cfg_err), 1);
      check("err_busy", 32'(tile_busy), 1);
      check("err_rd",   32'(fm_rd_en), 0);
      @(negedge clk);
      check("err_done_after", 32'(tile_done), 0);
      check("err_busy_after", 32'(tile_busy), 0);
      check("err_flag_after", 32'(cfg_err), 0);
      check("err_rd_after",   32'(fm_rd_en), 0);
      return;
    end

    for (int i = 0; i < n; i++) begin
      exp_a = exp_q.pop_front();
      check("issue_rd",   32'(fm_rd_en), 1);
      check("issue_addr", 32'(fm_rd_addr), 32'(exp_a));
      check("issue_re",   32'(re_fm_en), (i == 0) ? 1 : 0);
      check("issue_cnt",  nif_mult_k_mult_k, 32'(n - 1));
      check("issue_busy", 32'(tile_busy), 1);
      check("issue_done", 32'(tile_done), 0);
      if (noise) begin
        tile_start = 1'($urandom_range(0, 1));
        en = 1'($urandom_range(0, 1));
        quantify_add_end = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    tile_start = 1'b0; en = 1'b1; quantify_add_end = 1'b0;

    check("drain_rd",   32'(fm_rd_en), 0);
    check("drain_busy", 32'(tile_busy), 1);
    check("drain_done", 32'(tile_done), 0);
    for (int j = 0; j < drain_wait; j++) begin
      @(negedge clk);
      check("drain_wait_rd",   32'(fm_rd_en), 0);
      check("drain_wait_done", 32'(tile_done), 0);
      check("drain_wait_busy", 32'(tile_busy), 1);
    end
    quantify_add_end = 1'b1;
    @(negedge clk);
    quantify_add_end = 1'b0;
    check("done_pulse", 32'(tile_done), 1);
    check("done_busy",  32'(tile_busy), 1);
    check("done_err",   32'(cfg_err), 0);
    check("done_cnt",   nif_mult_k_mult_k, 32'(n - 1));
    check("done_rd",    32'(fm_rd_en), 0);
    @(negedge clk);
    check("post_done", 32'(tile_done), 0);
    check("post_busy", 32'(tile_busy), 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; tile_start = 1'b0; nif = '0; k = '0;
    fm_base_addr = '0; row_stride = '0; chan_stride = '0; quantify_add_end = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Scenario 1: nif=2, k=3, base 0x100, row stride 0x10, channel stride 0x40.
    run_tile(2, 3, 16'h0100, 16'h0010, 16'h0040, 1'b0, 2);
    // Scenario 2: nif=1, k=1 gives a single word.
    run_tile(1, 1, 16'h1234, 16'h0010, 16'h0040, 1'b0, 0);
    // Scenario 3: a zero-sized configuration.
    run_tile(0, 3, 16'h0200, 16'h0010, 16'h0040, 1'b0, 0);
    run_tile(2, 0, 16'h0200, 16'h0010, 16'h0040, 1'b0, 0);
    // tile_start while en=0 is ignored.
    @(negedge clk);
    nif = 16'd1; k = 3'd1; tile_start = 1'b1; en = 1'b0;
    @(negedge clk);
    tile_start = 1'b0; en = 1'b1;
    check("en0_busy", 32'(tile_busy), 0);
    check("en0_rd",   32'(fm_rd_en), 0);
    @(negedge clk);
    check("en0_busy2", 32'(tile_busy), 0);
    // Scenario 4: noise during the stream (restart, en drop, early retire).
    run_tile(2, 2, 16'h0300, 16'h0008, 16'h0020, 1'b1, 1);
    // Scenario 5: addresses wrap past 0xFFFF.
    run_tile(2, 3, 16'hFFFE, 16'h0001, 16'h0100, 1'b0, 1);

    // Scenario 6: reset asserted between edges while a tile is issuing.
    @(negedge clk);
    nif = 16'd2; k = 3'd3; fm_base_addr = 16'h0100; row_stride = 16'h0010; chan_stride = 16'h0040;
    tile_start = 1'b1; en = 1'b1;
    @(negedge clk);
    tile_start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_rd", 32'(fm_rd_en), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_busy", 32'(tile_busy), 0);
      check("post_reset_rd",   32'(fm_rd_en), 0);
    end
    run_tile(2, 3, 16'h0100, 16'h0010, 16'h0040, 1'b0, 0);

    // Random tiles.
    for (int t = 0; t < 8; t++)
      run_tile($urandom_range(1, 3), $urandom_range(1, 7), 16'($urandom), 16'($urandom),
               16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
